encoder_pipe_n: RTL

Parametrised, registered N-to-log2(N) encoder with valid/ready handshakes, used between the register-select decode stage and the bus multiplexer. It is the successor to the fixed 32-to-5 combinational bus encoder. It adds:
- configurable width
- defined multi-hot resolution
- error flags and a saturating error counter
- an optional round-robin priority pointer

---
 rtl/encoder_pipe_n.sv | 91 +++++++++
 1 files changed

// File: rtl/encoder_pipe_n.sv
// Registered N-to-log2(N) encoder with valid/ready handshake, multi-hot/none-hot flags
// and a saturating error counter. Define ENC_ROUND_ROBIN_EN for rotating priority.
module encoder_pipe_n #(
  parameter int N_IN  = 32,
  parameter int OUT_W = $clog2(N_IN)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_IN-1:0]  encIn,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] encOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             none_hot,
  output logic             multi_hot,
  output logic [7:0]       err_count
);

  localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

  logic [N_IN-1:0]  search;
  logic [OUT_W-1:0] off;
  logic [OUT_W-1:0] winner;
  logic             found;
  logic             zero;
  logic             multi;
  logic             accept;

`ifdef ENC_ROUND_ROBIN_EN
  localparam logic [OUT_W:0]   NIN_W = (OUT_W+1)'(N_IN);
  localparam logic [OUT_W-1:0] LAST  = OUT_W'(N_IN - 1);
  logic [OUT_W-1:0] ptr;
  logic [OUT_W:0]   wsum;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign zero     = ~|encIn;
  assign multi    = |(encIn & (encIn - ONE));

  // Round-robin rotates the request vector so bit 0 is the pointer position,
  // finds the lowest set bit, then maps the offset back modulo N_IN.
  always_comb begin
`ifdef ENC_ROUND_ROBIN_EN
    search = (encIn >> ptr) | (encIn << (N_IN - int'(ptr)));
`else
    search = encIn;
`endif
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (search[i] && !found) begin
        off   = OUT_W'(i);
        found = 1'b1;
      end
    end
`ifdef ENC_ROUND_ROBIN_EN
    wsum = {1'b0, ptr} + {1'b0, off};
    if (wsum >= NIN_W) wsum = wsum - NIN_W;
    winner = wsum[OUT_W-1:0];
`else
    winner = off;
`endif
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      encOut    <= '1;
      out_valid <= 1'b0;
      none_hot  <= 1'b0;
      multi_hot <= 1'b0;
      err_count <= '0;
`ifdef ENC_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else if (accept) begin
      encOut    <= zero ? '1 : winner;
      none_hot  <= zero;
      multi_hot <= multi;
      out_valid <= 1'b1;
      if ((zero || multi) && err_count != '1) err_count <= err_count + 8'd1;
`ifdef ENC_ROUND_ROBIN_EN
      if (!zero) ptr <= (winner == LAST) ? '0 : winner + OUT_W'(1);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
